// File: rtl/prim_sram_arbiter_mo.sv
// N:1 round-robin SRAM arbiter with a bounded read-outstanding window.
// Read responses are steered in order back to the issuing port.
module prim_sram_arbiter_mo #(
    parameter int unsigned N              = 4,
    parameter int unsigned SramDw         = 32,
    parameter int unsigned SramAw         = 12,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdxW           = $clog2(N),
    parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N-1:0]      req_i,
    input  logic [N-1:0]      req_write_i,
    input  logic [SramAw-1:0] req_addr_i  [N],
    input  logic [SramDw-1:0] req_wdata_i [N],
    input  logic [SramDw-1:0] req_wmask_i [N],
    output logic [N-1:0]      gnt_o,
    output logic [N-1:0]      rsp_rvalid_o,
    output logic [SramDw-1:0] rsp_rdata_o [N],
    output logic [1:0]        rsp_error_o [N],
    output logic              sram_req_o,
    input  logic              sram_gnt_i,
    output logic              sram_write_o,
    output logic [SramAw-1:0] sram_addr_o,
    output logic [SramDw-1:0] sram_wdata_o,
    output logic [SramDw-1:0] sram_wmask_o,
    input  logic              sram_rvalid_i,
    input  logic [SramDw-1:0] sram_rdata_i,
    input  logic [1:0]        sram_rerror_i,
    output logic [CntW-1:0]   outstanding_o,
    output logic              err_unexp_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

    logic [IdxW-1:0] ptr_q;
    logic [CntW-1:0] cnt_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];

    logic [N-1:0]    eligible;
    logic            win_valid;
    logic [IdxW-1:0] win_idx;
    logic            accept, push, pop, fifo_empty;

    // Eligibility looks only at registered occupancy, never at this cycle's pop.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            eligible[i] = req_i[i] & (req_write_i[i] | (cnt_q < MaxCnt));
        end
    end

    always_comb begin
        int unsigned idx;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_q) + k) % N;
            if (!win_valid && eligible[idx]) begin
                win_valid = 1'b1;
                win_idx   = IdxW'(idx);
            end
        end
    end

    always_comb begin
        sram_req_o   = win_valid;
        sram_write_o = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wmask_o = '0;
        if (win_valid) begin
            sram_write_o = req_write_i[win_idx];
            sram_addr_o  = req_addr_i[win_idx];
            sram_wdata_o = req_wdata_i[win_idx];
            sram_wmask_o = req_wmask_i[win_idx];
        end
    end

    assign accept     = win_valid & sram_gnt_i;
    assign push       = accept & ~sram_write_o;
    assign fifo_empty = (cnt_q == '0);
    assign pop        = sram_rvalid_i & ~fifo_empty;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            gnt_o[i]        = accept && (win_idx == IdxW'(i));
            rsp_rvalid_o[i] = pop && (fifo_q[rd_ptr_q] == IdxW'(i));
            rsp_rdata_o[i]  = sram_rdata_i;
            rsp_error_o[i]  = sram_rerror_i;
        end
    end

    assign err_unexp_o   = sram_rvalid_i & fifo_empty;
    assign outstanding_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (win_idx == IdxLast) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= win_idx;
        end
    end

endmodule

// File: tb/tb_prim_sram_arbiter_mo.sv
// Directed bench for prim_sram_arbiter_mo with N=4, MaxOutstanding=4.
module tb_prim_sram_arbiter_mo;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 12;
    localparam int unsigned MO = 4;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req, req_write;
    logic [AW-1:0] req_addr  [N];
    logic [DW-1:0] req_wdata [N];
    logic [DW-1:0] req_wmask [N];
    logic [N-1:0]  gnt, rsp_rvalid;
    logic [DW-1:0] rsp_rdata [N];
    logic [1:0]    rsp_error [N];
    logic          sram_req, sram_gnt, sram_write;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_wmask;
    logic          sram_rvalid;
    logic [DW-1:0] sram_rdata;
    logic [1:0]    sram_rerror;
    logic [CW-1:0] outstanding;
    logic          err_unexp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prim_sram_arbiter_mo #(
        .N(N), .SramDw(DW), .SramAw(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .req_write_i(req_write), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
        .gnt_o(gnt), .rsp_rvalid_o(rsp_rvalid), .rsp_rdata_o(rsp_rdata),
        .rsp_error_o(rsp_error),
        .sram_req_o(sram_req), .sram_gnt_i(sram_gnt), .sram_write_o(sram_write),
        .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_wmask_o(sram_wmask),
        .sram_rvalid_i(sram_rvalid), .sram_rdata_i(sram_rdata),
        .sram_rerror_i(sram_rerror),
        .outstanding_o(outstanding), .err_unexp_o(err_unexp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; req_write = '0; sram_gnt = 1'b0;
        sram_rvalid = 1'b0; sram_rdata = '0; sram_rerror = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i]  = AW'(12'h100 + i);
            req_wdata[i] = DW'(32'hD000_0000 + i);
            req_wmask[i] = DW'(32'hF0F0_0000 + i);
        end

        // Reset state with idle inputs
        tick(); tick();
        settle();
        chk("rst_gnt", gnt, 0);
        chk("rst_sram_req", sram_req, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_rsp_rvalid", rsp_rvalid, 0);
        chk("rst_err", err_unexp, 0);
        chk("rst_addr", sram_addr, 0);
        rst_n = 1'b1;
        tick();

        // Round-robin: all read, response one cycle after each grant
        sram_gnt = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req = (k < 5) ? 4'b1111 : 4'b0000;
            sram_rvalid = (k > 0);
            sram_rdata = DW'(32'hA0 + k);
            settle();
            chk("rr_gnt", gnt, (k < 5) ? (64'd1 << (k % 4)) : 64'd0);
            chk("rr_rsp", rsp_rvalid, (k > 0) ? (64'd1 << ((k - 1) % 4)) : 64'd0);
            chk("rr_cnt", outstanding, (k == 0) ? 0 : 1);
            if (k == 1) chk("rr_addr", sram_addr, 12'h101);
            tick();
        end
        sram_rvalid = 1'b0;
        settle();
        chk("rr_cnt_end", outstanding, 0);

        // Backpressure on port 2 (ptr is 1)
        req = 4'b0100;
        sram_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_req", sram_req, 1);
            chk("bp_gnt", gnt, 0);
            chk("bp_addr", sram_addr, 12'h102);
            tick();
        end
        sram_gnt = 1'b1;
        settle();
        chk("bp_gnt_final", gnt, 4'b0100);
        tick();
        // ptr must now be 3: all ports writing, port 3 wins; drain port 2 read
        req = 4'b1111; req_write = 4'b1111;
        sram_rvalid = 1'b1; sram_rdata = 32'h55;
        settle();
        chk("bp_ptr3_gnt", gnt, 4'b1000);
        chk("wr_write", sram_write, 1);
        chk("wr_wdata", sram_wdata, 32'hD000_0003);
        chk("wr_wmask", sram_wmask, 32'hF0F0_0003);
        chk("bp_rsp", rsp_rvalid, 4'b0100);
        tick();
        sram_rvalid = 1'b0; req = '0; req_write = '0;
        settle();
        chk("wr_no_push", outstanding, 0);

        // Window full: 4 reads on port 1
        req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("win_gnt", gnt, 4'b0010);
            chk("win_cnt", outstanding, k);
            tick();
        end
        chk("win_full", outstanding, 4);
        req = 4'b0110; req_write = 4'b0100;
        settle();
        chk("win_wr_pass", gnt, 4'b0100);
        chk("win_wr_addr", sram_addr, 12'h102);
        tick();
        req = 4'b0010; req_write = '0; sram_rvalid = 1'b1;
        settle();
        chk("win_same_cycle_pop", gnt, 0);
        chk("win_req_blocked", sram_req, 0);
        chk("win_rsp", rsp_rvalid, 4'b0010);
        tick();
        sram_rvalid = 1'b0;
        settle();
        chk("win_cnt3", outstanding, 3);
        chk("win_regrant", gnt, 4'b0010);
        tick();
        req = '0; sram_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("win_drain_rsp", rsp_rvalid, 4'b0010);
            chk("win_drain_cnt", outstanding, 4 - k);
            tick();
        end
        sram_rvalid = 1'b0;
        settle();
        chk("win_empty", outstanding, 0);

        // Out-of-order ports, in-order data (ptr is 2)
        req = 4'b1000;
        settle();
        chk("ooo_g3", gnt, 4'b1000);
        tick();
        req = 4'b0001;
        settle();
        chk("ooo_g0", gnt, 4'b0001);
        tick();
        req = 4'b0100; sram_rvalid = 1'b1; sram_rdata = 32'hAAAA_0001; sram_rerror = 2'b01;
        settle();
        chk("ooo_g2", gnt, 4'b0100);
        chk("ooo_rspA", rsp_rvalid, 4'b1000);
        chk("ooo_dataA", rsp_rdata[3], 32'hAAAA_0001);
        chk("ooo_errA", rsp_error[1], 2'b01);
        tick();
        req = '0; sram_rdata = 32'hBBBB_0002; sram_rerror = 2'b10;
        settle();
        chk("ooo_rspB", rsp_rvalid, 4'b0001);
        chk("ooo_dataB", rsp_rdata[0], 32'hBBBB_0002);
        chk("ooo_errB", rsp_error[2], 2'b10);
        tick();
        sram_rvalid = 1'b0; sram_rdata = '0; sram_rerror = '0;
        settle();
        chk("ooo_gap", rsp_rvalid, 0);
        chk("ooo_gap_cnt", outstanding, 1);
        tick();
        sram_rvalid = 1'b1; sram_rdata = 32'hCCCC_0003; sram_rerror = 2'b11;
        settle();
        chk("ooo_rspC", rsp_rvalid, 4'b0100);
        chk("ooo_dataC", rsp_rdata[2], 32'hCCCC_0003);
        chk("ooo_errC", rsp_error[0], 2'b11);
        tick();

        // Unexpected response with nothing outstanding
        sram_rdata = '0; sram_rerror = '0;
        settle();
        chk("unexp_err", err_unexp, 1);
        chk("unexp_rsp", rsp_rvalid, 0);
        chk("unexp_cnt", outstanding, 0);
        tick();
        sram_rvalid = 1'b0;
        settle();
        chk("unexp_pulse_end", err_unexp, 0);
        chk("unexp_cnt_after", outstanding, 0);

        // Reset mid-flight (ptr is 3, so port 0 then port 1)
        req = 4'b0011;
        settle();
        chk("rmf_g0", gnt, 4'b0001);
        tick();
        settle();
        chk("rmf_g1", gnt, 4'b0010);
        tick();
        req = '0; sram_gnt = 1'b0;
        settle();
        chk("rmf_cnt2", outstanding, 2);
        rst_n = 1'b0;
        settle();
        chk("rmf_rst_cnt", outstanding, 0);
        chk("rmf_rst_gnt", gnt, 0);
        chk("rmf_rst_req", sram_req, 0);
        chk("rmf_rst_rsp", rsp_rvalid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        sram_rvalid = 1'b1;
        settle();
        chk("rmf_unexp", err_unexp, 1);
        chk("rmf_unexp_rsp", rsp_rvalid, 0);
        tick();
        sram_rvalid = 1'b0;
        // ptr back at 0 after reset
        req = 4'b1111; req_write = 4'b1111; sram_gnt = 1'b1;
        settle();
        chk("rmf_ptr0", gnt, 4'b0001);
        tick();
        req = '0; req_write = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
